// File: rtl/bpu_btb_pkg.sv
// Shared constants, counter encoding and counter-step helper for the branch target buffer.
package bpu_btb_pkg;

  localparam int unsigned BP_ADDR_W_DEF    = 5;
  localparam int unsigned BP_ADDR_BITS_DEF = 32;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Two-bit saturating step toward the resolved outcome.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      case (c)
        CTR_SNT: n = CTR_WNT;
        CTR_WNT: n = CTR_WT;
        default: n = CTR_ST;
      endcase
    end else begin
      case (c)
        CTR_ST:  n = CTR_WT;
        CTR_WT:  n = CTR_WNT;
        default: n = CTR_SNT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/bpu_btb_match_enc.sv
// Lowest-index one-hot (or multi-hot) to binary encoder with a hit flag.
module bp_match_enc #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 5
) (
  input  logic [N-1:0] vec,
  output logic         hit,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit = |vec;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[N-1-i]) idx = W'(N-1-i);
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Fully associative branch target buffer with 2-bit counters and
// free-first / round-robin replacement.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int unsigned BP_ADDR_W    = BP_ADDR_W_DEF,
  parameter int unsigned BP_ADDR_BITS = BP_ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 bp_taken,
  output logic                 bp_match,
  output logic [BP_ADDR_W-1:0] bp_addr,
  output logic [31:0]          bp_target,
  input  logic                 ac2bp_stall,
  input  logic                 flush_valid,
  input  logic                 flush_new_pc,
  input  logic                 flush_type,
  input  logic [BP_ADDR_W-1:0] flush_addr,
  input  logic [31:0]          flush_bp_pc,
  input  logic [31:0]          flush_pc
);

  localparam int unsigned N = 1 << BP_ADDR_W;

  logic [N-1:0]            valid;
  logic [BP_ADDR_BITS-1:0] tag    [N];
  logic [31:0]             target [N];
  ctr_e                    ctr    [N];
  logic [BP_ADDR_W-1:0]    rr_ptr;

  logic [N-1:0]            lk_vec;
  logic                    lk_hit;
  logic [BP_ADDR_W-1:0]    lk_idx;

  logic [2*N-1:0]          up_vec;
  logic                    up_hit;
  logic [BP_ADDR_W:0]      up_idx;

  logic                    upd;
  logic                    dup;
  logic                    free;
  logic                    ctr_we;
  logic [BP_ADDR_W-1:0]    ctr_idx;
  ctr_e                    ctr_wdata;
  logic                    alloc;
  logic [BP_ADDR_W-1:0]    alloc_idx;

  // Fetch-side tag compare against every valid entry.
  always_comb begin
    lk_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lk_vec[i] = valid[i] && (tag[i] == if_pc[BP_ADDR_BITS-1:0]);
    end
  end

  bp_match_enc #(.N(N), .W(BP_ADDR_W)) u_lookup_enc (
    .vec (lk_vec),
    .hit (lk_hit),
    .idx (lk_idx)
  );

  // Lookup results, forced to zero on miss and while reset is held.
  always_comb begin
    bp_match  = 1'b0;
    bp_taken  = 1'b0;
    bp_addr   = '0;
    bp_target = '0;
    if (!rst && lk_hit) begin
      bp_match  = 1'b1;
      bp_taken  = ctr[lk_idx][1];
      bp_addr   = lk_idx;
      bp_target = target[lk_idx];
    end
  end

  // Update-side search: duplicate hits occupy the low half and free slots the
  // high half, so one lowest-index encode prefers a duplicate over a free entry
  // and the top index bit tells which kind was found.
  always_comb begin
    up_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      up_vec[i]   = valid[i] && (tag[i] == flush_bp_pc[BP_ADDR_BITS-1:0]);
      up_vec[N+i] = ~valid[i];
    end
  end

  bp_match_enc #(.N(2*N), .W(BP_ADDR_W+1)) u_update_enc (
    .vec (up_vec),
    .hit (up_hit),
    .idx (up_idx)
  );

  // Decode the accepted resolve into a counter step or an allocation.
  always_comb begin
    upd       = flush_valid & ~ac2bp_stall;
    dup       = up_hit & ~up_idx[BP_ADDR_W];
    free      = up_hit &  up_idx[BP_ADDR_W];
    ctr_we    = 1'b0;
    ctr_idx   = flush_addr;
    ctr_wdata = ctr_next(ctr[flush_addr], flush_type);
    alloc     = 1'b0;
    alloc_idx = free ? up_idx[BP_ADDR_W-1:0] : rr_ptr;
    if (upd) begin
      if (!flush_new_pc) begin
        ctr_we = 1'b1;
      end else if (dup) begin
        ctr_we    = 1'b1;
        ctr_idx   = up_idx[BP_ADDR_W-1:0];
        ctr_wdata = ctr_next(ctr[up_idx[BP_ADDR_W-1:0]], flush_type);
      end else begin
        alloc = 1'b1;
      end
    end
  end

  // Valid bits, counters and replacement pointer; reset wins over any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      rr_ptr <= '0;
      for (int unsigned i = 0; i < N; i++) ctr[i] <= CTR_WNT;
    end else begin
      if (ctr_we) ctr[ctr_idx] <= ctr_wdata;
      if (alloc) begin
        valid[alloc_idx] <= 1'b1;
        ctr[alloc_idx]   <= flush_type ? CTR_WT : CTR_WNT;
        if (!free) rr_ptr <= rr_ptr + BP_ADDR_W'(1);
      end
    end
  end

  // Tag and target payload; contents are meaningless until the entry is valid.
  always_ff @(posedge clk) begin
    if (!rst && alloc) begin
      tag[alloc_idx]    <= flush_bp_pc[BP_ADDR_BITS-1:0];
      target[alloc_idx] <= flush_pc;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed table-driven bench for bpu_btb plus hand sequences for fill,
// replacement, stall and reset corners.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        bp_taken;
  logic        bp_match;
  logic [4:0]  bp_addr;
  logic [31:0] bp_target;
  logic        ac2bp_stall;
  logic        flush_valid;
  logic        flush_new_pc;
  logic        flush_type;
  logic [4:0]  flush_addr;
  logic [31:0] flush_bp_pc;
  logic [31:0] flush_pc;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  bpu_btb #(.BP_ADDR_W(5), .BP_ADDR_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .bp_taken     (bp_taken),
    .bp_match     (bp_match),
    .bp_addr      (bp_addr),
    .bp_target    (bp_target),
    .ac2bp_stall  (ac2bp_stall),
    .flush_valid  (flush_valid),
    .flush_new_pc (flush_new_pc),
    .flush_type   (flush_type),
    .flush_addr   (flush_addr),
    .flush_bp_pc  (flush_bp_pc),
    .flush_pc     (flush_pc)
  );

  typedef struct {
    string       nm;
    logic        fv, st, np, ty;
    logic [4:0]  fa;
    logic [31:0] bpc, fpc, ipc;
    logic        em, et;
    logic [4:0]  ea;
    logic [31:0] etg;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(string nm, logic fv, logic st, logic np, logic ty,
                              logic [4:0] fa, logic [31:0] bpc, logic [31:0] fpc,
                              logic [31:0] ipc, logic em, logic et, logic [4:0] ea,
                              logic [31:0] etg);
    vec_t v;
    v.nm = nm; v.fv = fv; v.st = st; v.np = np; v.ty = ty; v.fa = fa;
    v.bpc = bpc; v.fpc = fpc; v.ipc = ipc;
    v.em = em; v.et = et; v.ea = ea; v.etg = etg;
    return v;
  endfunction

  task automatic drv(input logic fv, input logic st, input logic np, input logic ty,
                     input logic [4:0] fa, input logic [31:0] bpc,
                     input logic [31:0] fpc, input logic [31:0] ipc);
    flush_valid  = fv;
    ac2bp_stall  = st;
    flush_new_pc = np;
    flush_type   = ty;
    flush_addr   = fa;
    flush_bp_pc  = bpc;
    flush_pc     = fpc;
    if_pc        = ipc;
  endtask

  task automatic chk(input string nm, input logic em, input logic et,
                     input logic [4:0] ea, input logic [31:0] etg);
    nvec++;
    if ({bp_match, bp_taken, bp_addr, bp_target} !== {em, et, ea, etg}) begin
      nmis++;
      $display("FAIL %s: got match=%0b taken=%0b addr=%0d target=%h, want match=%0b taken=%0b addr=%0d target=%h",
               nm, bp_match, bp_taken, bp_addr, bp_target, em, et, ea, etg);
    end
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt, input logic ty);
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b1, ty, 5'd0, pc, tgt, 32'h0);
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic em,
                      input logic et, input logic [4:0] ea, input logic [31:0] etg);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, pc);
    #1 chk(nm, em, et, ea, etg);
  endtask

  initial begin
    // name          fv st np ty fa   bp_pc         flush_pc      if_pc         m  t  a  target
    vt[0]  = mk("rst_lookup", 0,0,0,0, 0, 32'h0,   32'h0,   32'h100, 0,0,0, 32'h0);
    vt[1]  = mk("alloc_same", 1,0,1,1, 0, 32'h100, 32'h180, 32'h100, 0,0,0, 32'h0);
    vt[2]  = mk("alloc_hit",  0,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[3]  = mk("dec_10",     1,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[4]  = mk("dec_01",     1,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[5]  = mk("dec_00",     1,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[6]  = mk("inc_00sat",  1,0,0,1, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[7]  = mk("inc_01",     1,0,0,1, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[8]  = mk("inc_10",     1,0,0,1, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[9]  = mk("inc_11",     1,0,0,1, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[10] = mk("dec_11sat",  1,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[11] = mk("dec_10b",    1,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[12] = mk("ctr_01",     0,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[13] = mk("stall_a1",   1,1,1,1, 0, 32'h300, 32'h380, 32'h300, 0,0,0, 32'h0);
    vt[14] = mk("stall_a2",   1,1,1,1, 0, 32'h300, 32'h380, 32'h300, 0,0,0, 32'h0);
    vt[15] = mk("stall_a3",   1,1,1,1, 0, 32'h300, 32'h380, 32'h300, 0,0,0, 32'h0);
    vt[16] = mk("stall_none", 0,0,0,0, 0, 32'h0,   32'h0,   32'h300, 0,0,0, 32'h0);
    vt[17] = mk("stall_inc",  1,1,0,1, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[18] = mk("stall_ctr",  0,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,0,0, 32'h180);
    vt[19] = mk("dup_alloc",  1,0,1,1, 0, 32'h100, 32'h999, 32'h100, 1,0,0, 32'h180);
    vt[20] = mk("dup_after",  0,0,0,0, 0, 32'h0,   32'h0,   32'h100, 1,1,0, 32'h180);
    vt[21] = mk("alloc_2nd",  1,0,1,0, 0, 32'h104, 32'h444, 32'h104, 0,0,0, 32'h0);
    vt[22] = mk("hit_2nd",    0,0,0,0, 0, 32'h0,   32'h0,   32'h104, 1,0,1, 32'h444);

    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h100);
    #1 chk("in_reset", 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      drv(vt[i].fv, vt[i].st, vt[i].np, vt[i].ty, vt[i].fa, vt[i].bpc, vt[i].fpc, vt[i].ipc);
      #1 chk(vt[i].nm, vt[i].em, vt[i].et, vt[i].ea, vt[i].etg);
    end

    // Fresh table, fill every entry in order.
    @(negedge clk);
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) alloc(32'(i * 4), 32'h1000 + 32'(i), 1'(i % 2));
    for (int i = 0; i < 32; i++)
      look("fill_hit", 32'(i * 4), 1'b1, 1'(i % 2), 5'(i), 32'h1000 + 32'(i));

    // Full table: round-robin from 0.
    alloc(32'h200, 32'h2000, 1'b1);
    look("rr0_evict", 32'h0,   1'b0, 1'b0, 5'd0, 32'h0);
    look("rr0_hit",   32'h200, 1'b1, 1'b1, 5'd0, 32'h2000);
    alloc(32'h204, 32'h2004, 1'b0);
    look("rr1_hit",   32'h204, 1'b1, 1'b0, 5'd1, 32'h2004);
    look("rr1_evict", 32'h4,   1'b0, 1'b0, 5'd0, 32'h0);

    // Duplicate allocate must only step the counter (10 -> 01), not move rr_ptr.
    alloc(32'h200, 32'h9999, 1'b0);
    look("dup_full",  32'h200, 1'b1, 1'b0, 5'd0, 32'h2000);

    // Stalled allocate must not land or advance rr_ptr.
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 32'h500, 32'h5000, 32'h0);
    look("stall_full", 32'h500, 1'b0, 1'b0, 5'd0, 32'h0);

    alloc(32'h208, 32'h2008, 1'b1);
    look("rr2_hit",   32'h208, 1'b1, 1'b1, 5'd2, 32'h2008);

    // Walk rr_ptr through 3..31 and confirm it wraps to 0.
    for (int k = 0; k < 29; k++) alloc(32'h400 + 32'(k * 4), 32'h4000 + 32'(k), 1'b0);
    look("rr3_hit",   32'h400, 1'b1, 1'b0, 5'd3,  32'h4000);
    look("rr31_hit",  32'h470, 1'b1, 1'b0, 5'd31, 32'h401C);
    alloc(32'h600, 32'h6000, 1'b1);
    look("rr_wrap",   32'h600, 1'b1, 1'b1, 5'd0,  32'h6000);

    // Reset coincident with an allocate: everything invalid, allocate dropped.
    @(negedge clk);
    rst = 1'b1;
    drv(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h700, 32'h7000, 32'h600);
    #1 chk("rst_cycle", 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h600);
    #1 chk("post_rst_old", 1'b0, 1'b0, 5'd0, 32'h0);
    look("post_rst_new", 32'h700, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bpu_btb.md
BPU_BTB -- requirements
Module: bpu_btb

Interface
REQ-001 Parameter BP_ADDR_W, default `BP_ADDR_W (5), entry-index width; table depth N = 2^BP_ADDR_W (32 entries).
REQ-002 Parameter BP_ADDR_BITS, default `BP_ADDR_BITS (32), tag width; tag = pc[BP_ADDR_BITS-1:0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 if_pc  input  32  fetch PC to look up.
REQ-006 bp_taken  output  1  predicted taken: hit and counter[1]=1.
REQ-007 bp_match  output  1  if_pc tag hit in a valid entry.
REQ-008 bp_addr  output  BP_ADDR_W  index of the hit entry; 0 on miss.
REQ-009 bp_target  output  32  target of the hit entry; 0 on miss.
REQ-010 ac2bp_stall  input  1  pipeline stall; suppresses updates while high.
REQ-011 flush_valid  input  1  execute-stage branch resolve, qualified by exu valid.
REQ-012 flush_new_pc  input  1  branch was not in the table; allocate it.
REQ-013 flush_type  input  1  resolved outcome: 1 taken, 0 not taken.
REQ-014 flush_addr  input  BP_ADDR_W  entry index carried with the branch from lookup.
REQ-015 flush_bp_pc  input  32  branch PC; low BP_ADDR_BITS used as tag.
REQ-016 flush_pc  input  32  branch target (pc+imm).

Function
REQ-017 Entry state: valid bit, tag, 32-bit target, 2-bit saturating counter.
REQ-018 Lookup is combinational, 0-cycle latency: compare if_pc tag against all valid entries and return results in the same cycle.
REQ-019 Multiple tag hits (not reachable by REQ-023) shall resolve to the lowest index.
REQ-020 Update is accepted when upd = flush_valid & ~ac2bp_stall and takes effect at the next clock edge. Lookup in the same cycle sees pre-update state.
REQ-021 Update with flush_new_pc=0: counter[flush_addr] increments on flush_type=1 and decrements on 0. It saturates at 2'b11 and 2'b00. Tag and target are unchanged.
REQ-022 Update with flush_new_pc=1 allocates a victim. The victim is the lowest-index invalid entry; if every entry is valid, the victim is the round-robin pointer rr_ptr. Victim writes: valid=1, tag=flush_bp_pc tag, target=flush_pc, counter = flush_type ? 2'b10 : 2'b01.
REQ-023 Duplicate guard: if flush_new_pc=1 and flush_bp_pc tag already hits a valid entry, update that entry's counter per REQ-021. No allocation occurs and rr_ptr is not advanced.
REQ-024 rr_ptr is BP_ADDR_W bits and advances by 1 only on an allocation that uses it. It wraps from N-1 to 0.
REQ-025 Allocation into an invalid entry does not advance rr_ptr.
REQ-026 With flush_valid=1 and ac2bp_stall=1, no state changes.

Reset
REQ-027 While rst=1 at a clock edge, the block clears:
- all valid bits;
- rr_ptr to 0;
- all counters to 2'b01.
Tags and targets are don't-care.
REQ-028 During reset and in the cycle after it, outputs for any if_pc are bp_match=0, bp_taken=0, bp_addr=0, bp_target=0.
REQ-029 Reset has priority over a simultaneous update. An update in progress at reset assertion is discarded.

Structure
REQ-030 BP_ADDR_W, BP_ADDR_BITS and the counter encodings (SNT=00, WNT=01, WT=10, ST=11) shall be defined in macro.v alongside the existing core defines.
REQ-031 One sub-module, bp_match_enc, shall perform a lowest-index one-hot-to-binary encode with a hit flag. It is instantiated twice: once for lookup, once for the update-side duplicate and free-entry search.
REQ-032 Table storage shall be flops, not SRAM, because the lookup is combinational.

Verification
REQ-033 Reset, then lookup if_pc=0x100 -> bp_match=0, bp_taken=0, bp_addr=0, bp_target=0.
REQ-034 Update (new_pc=1, bp_pc=0x100, flush_pc=0x180, type=1), then next-cycle lookup 0x100:
- bp_match=1, bp_addr=0, bp_target=0x180, bp_taken=1 (counter 10);
- in the update cycle itself, the lookup returns bp_match=0.
REQ-035 Entry 0 at counter 10: two not-taken updates at flush_addr=0 give counter 00 (bp_taken=0). A third gives counter 00 (saturate). Four taken updates give counter 11, then saturate.
REQ-036 Fill 32 distinct PCs 0x0..0x7C, then allocate 0x200 -> entry 0 is replaced (rr_ptr 0->1). Lookup 0x0 gives bp_match=0; lookup 0x200 gives bp_addr=0.
REQ-037 Allocate bp_pc=0x100 twice -> a single entry exists and the second update adjusts its counter. rr_ptr and the valid count are unchanged.
REQ-038 flush_valid=1 with ac2bp_stall=1 for 3 cycles -> table and rr_ptr are unchanged. Assert rst in the same cycle as an update -> all entries are invalid afterward.
